uart: RTL and testbench

UART -- requirements
Module: uart

---
 rtl/uart.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// uart -- oversampled serial receiver and transmitter, each buffered by a
// small first-word-fall-through FIFO. One baud tick every DVSR+1 clocks;
// 16 ticks per data bit, SB_TICK ticks in the stop bit.
//
// Ports
//   i_clk       single clock, rising edge
//   i_reset     synchronous, active high
//   i_rd_uart   pop one word from the RX FIFO
//   i_wr_uart   push i_wr_data into the TX FIFO
//   i_rx        serial receive line (idle high)
//   i_wr_data   word to transmit
//   o_tx_full   TX FIFO full
//   o_rx_empty  RX FIFO empty
//   o_tx        serial transmit line (registered)
//   o_rd_data   head word of the RX FIFO (valid while o_rx_empty==0)

// Circular buffer, 2^AW words, registered flags, head word shown combinationally.
module uart_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wp, rp, wp_succ, rp_succ;
  logic          we, re;

  // A write into a full FIFO is allowed only when the head leaves on the same edge.
  assign we      = wr & (~full | rd);
  assign re      = rd & ~empty;
  assign wp_succ = wp + AW'(1);
  assign rp_succ = rp + AW'(1);
  assign rdata   = mem[rp];

  always_ff @(posedge clk)
    if (we) mem[wp] <= wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (we) wp <= wp_succ;
      if (re) rp <= rp_succ;
      // Simultaneous push and pop leaves the occupancy, and so both flags, unchanged.
      if (we & ~re) begin
        empty <= 1'b0;
        full  <= (wp_succ == rp);
      end else if (re & ~we) begin
        full  <= 1'b0;
        empty <= (rp_succ == wp);
      end
    end
  end
endmodule

module uart #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int DVSR     = 162,
  parameter int DVSR_BIT = 8,
  parameter int FIFO_W   = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rd_uart,
  input  logic            i_wr_uart,
  input  logic            i_rx,
  input  logic [DBIT-1:0] i_wr_data,
  output logic            o_tx_full,
  output logic            o_rx_empty,
  output logic            o_tx,
  output logic [DBIT-1:0] o_rd_data
);
  // Tick counter is 4 bits unless the stop period needs more.
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- baud generator ----------------
  logic [DVSR_BIT-1:0] cnt;
  logic                tick;
  assign tick = (cnt == DVSR_BIT'(DVSR));

  always_ff @(posedge i_clk)
    if (i_reset || tick) cnt <= '0;
    else                 cnt <= cnt + DVSR_BIT'(1);

  // ---------------- receiver ----------------
  state_t          rx_state, rx_state_nx;
  logic [SW-1:0]   rx_s, rx_s_nx;
  logic [NW-1:0]   rx_n, rx_n_nx;
  logic [DBIT-1:0] rx_b, rx_b_nx;
  logic            rx_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state <= IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
    end else begin
      rx_state <= rx_state_nx;
      rx_s     <= rx_s_nx;
      rx_n     <= rx_n_nx;
      rx_b     <= rx_b_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_s_nx     = rx_s;
    rx_n_nx     = rx_n;
    rx_b_nx     = rx_b;
    case (rx_state)
      IDLE:
        if (!i_rx) begin
          rx_state_nx = START;
          rx_s_nx     = '0;
        end
      // Half a bit in, so data samples land mid-bit.
      START:
        if (tick) begin
          if (rx_s == SW'(7)) begin
            rx_state_nx = DATA;
            rx_s_nx     = '0;
            rx_n_nx     = '0;
          end else rx_s_nx = rx_s + SW'(1);
        end
      DATA:
        if (tick) begin
          if (rx_s == SW'(15)) begin
            rx_s_nx = '0;
            rx_b_nx = {i_rx, rx_b[DBIT-1:1]};
            if (rx_n == NW'(DBIT-1)) rx_state_nx = STOP;
            else                     rx_n_nx     = rx_n + NW'(1);
          end else rx_s_nx = rx_s + SW'(1);
        end
      STOP:
        if (tick) begin
          if (rx_s == SW'(SB_TICK-1)) rx_state_nx = IDLE;
          else                        rx_s_nx     = rx_s + SW'(1);
        end
      default: rx_state_nx = IDLE;
    endcase
  end

  always_comb begin
    rx_done = (rx_state == STOP) && tick && (rx_s == SW'(SB_TICK-1));
  end

  // ---------------- transmitter ----------------
  state_t          tx_state, tx_state_nx;
  logic [SW-1:0]   tx_s, tx_s_nx;
  logic [NW-1:0]   tx_n, tx_n_nx;
  logic [DBIT-1:0] tx_b, tx_b_nx;
  logic            tx_done, tx_bit;
  logic            tx_empty;
  logic [DBIT-1:0] tx_head;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state <= IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      o_tx     <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_s     <= tx_s_nx;
      tx_n     <= tx_n_nx;
      tx_b     <= tx_b_nx;
      o_tx     <= tx_bit;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_s_nx     = tx_s;
    tx_n_nx     = tx_n;
    tx_b_nx     = tx_b;
    case (tx_state)
      IDLE:
        if (!tx_empty) begin
          tx_state_nx = START;
          tx_s_nx     = '0;
          tx_b_nx     = tx_head;
        end
      START:
        if (tick) begin
          if (tx_s == SW'(15)) begin
            tx_state_nx = DATA;
            tx_s_nx     = '0;
            tx_n_nx     = '0;
          end else tx_s_nx = tx_s + SW'(1);
        end
      DATA:
        if (tick) begin
          if (tx_s == SW'(15)) begin
            tx_s_nx = '0;
            tx_b_nx = tx_b >> 1;
            if (tx_n == NW'(DBIT-1)) tx_state_nx = STOP;
            else                     tx_n_nx     = tx_n + NW'(1);
          end else tx_s_nx = tx_s + SW'(1);
        end
      STOP:
        if (tick) begin
          if (tx_s == SW'(SB_TICK-1)) tx_state_nx = IDLE;
          else                        tx_s_nx     = tx_s + SW'(1);
        end
      default: tx_state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_done = (tx_state == STOP) && tick && (tx_s == SW'(SB_TICK-1));
    case (tx_state)
      START:   tx_bit = 1'b0;
      DATA:    tx_bit = tx_b[0];
      default: tx_bit = 1'b1;
    endcase
  end

  // ---------------- FIFOs ----------------
  uart_fifo #(.W(DBIT), .AW(FIFO_W)) rx_fifo (
    .clk(i_clk), .reset(i_reset), .rd(i_rd_uart), .wr(rx_done),
    .wdata(rx_b_nx), .rdata(o_rd_data), .empty(o_rx_empty), .full()
  );

  // The word in flight stays in the TX FIFO until its stop bit ends.
  uart_fifo #(.W(DBIT), .AW(FIFO_W)) tx_fifo (
    .clk(i_clk), .reset(i_reset), .rd(tx_done), .wr(i_wr_uart),
    .wdata(i_wr_data), .rdata(tx_head), .empty(tx_empty), .full(o_tx_full)
  );
endmodule

// File: tb/tb_uart.sv
// Directed bench for uart at DVSR=1 (32 clocks per bit), 4-deep FIFOs.
module tb_uart;
  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rd_uart = 1'b0;
  logic       i_wr_uart = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] i_wr_data = 8'h00;
  logic       o_tx_full, o_rx_empty, o_tx;
  logic [7:0] o_rd_data;

  int checks = 0;
  int fails  = 0;

  localparam int BITCLK = 32;

  uart #(.DBIT(8), .SB_TICK(16), .DVSR(1), .DVSR_BIT(8), .FIFO_W(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rd_uart(i_rd_uart), .i_wr_uart(i_wr_uart),
    .i_rx(i_rx), .i_wr_data(i_wr_data), .o_tx_full(o_tx_full), .o_rx_empty(o_rx_empty),
    .o_tx(o_tx), .o_rd_data(o_rd_data)
  );

  always #5 i_clk = ~i_clk;

  // All driving and sampling happens on the falling edge.
  task automatic clks(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic send_rx(input logic [7:0] d);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      i_rx = frame[i];
      clks(BITCLK);
    end
    i_rx = 1'b1;
    clks(4);
  endtask

  task automatic pulse_rd();
    i_rd_uart = 1'b1;
    clks(1);
    i_rd_uart = 1'b0;
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    i_wr_data = d;
    i_wr_uart = 1'b1;
    clks(1);
    i_wr_uart = 1'b0;
  endtask

  // Wait for a start bit, then sample each bit near its middle.
  task automatic capture_tx(output logic [7:0] d, output logic st, output logic sp,
                            output bit ok);
    int t;
    ok = 1'b0; t = 0; d = 8'hxx; st = 1'bx; sp = 1'bx;
    while (!ok && t < 4000) begin
      clks(1);
      t++;
      if (o_tx === 1'b0) ok = 1'b1;
    end
    if (ok) begin
      clks(15);
      st = o_tx;
      for (int b = 0; b < 8; b++) begin
        clks(BITCLK);
        d[b] = o_tx;
      end
      clks(BITCLK);
      sp = o_tx;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    clks(3);
    i_reset = 1'b0;
    clks(1);
    checks++; if (o_tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", o_tx); end
    checks++; if (o_rx_empty !== 1'b1) begin fails++; $display("FAIL reset_rx_empty: got %b want 1", o_rx_empty); end
    checks++; if (o_tx_full !== 1'b0) begin fails++; $display("FAIL reset_tx_full: got %b want 0", o_tx_full); end
  endtask

  task automatic test_rx_single();
    send_rx(8'h05);
    checks++; if (o_rx_empty !== 1'b0) begin fails++; $display("FAIL rx1_empty: got %b want 0", o_rx_empty); end
    checks++; if (o_rd_data !== 8'h05) begin fails++; $display("FAIL rx1_data: got %h want 05", o_rd_data); end
    pulse_rd();
    checks++; if (o_rx_empty !== 1'b1) begin fails++; $display("FAIL rx1_pop_empty: got %b want 1", o_rx_empty); end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] want [4];
    want = '{8'h00, 8'h14, 8'hAA, 8'hFF};
    send_rx(8'h00); send_rx(8'h14); send_rx(8'hAA); send_rx(8'hFF); send_rx(8'h32);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_rx_empty !== 1'b0 || o_rd_data !== want[i]) begin
        fails++;
        $display("FAIL rx_ovf_word%0d: got %h empty=%b want %h empty=0", i, o_rd_data, o_rx_empty, want[i]);
      end
      pulse_rd();
    end
    checks++; if (o_rx_empty !== 1'b1) begin fails++; $display("FAIL rx_ovf_drop: empty=%b want 1 (5th word must be dropped)", o_rx_empty); end
  endtask

  task automatic test_rx_read_empty();
    pulse_rd();
    pulse_rd();
    checks++; if (o_rx_empty !== 1'b1) begin fails++; $display("FAIL rd_empty_flag: got %b want 1", o_rx_empty); end
    // Pointers untouched: the next word must come back as the head.
    send_rx(8'h5A);
    checks++;
    if (o_rx_empty !== 1'b0 || o_rd_data !== 8'h5A) begin
      fails++; $display("FAIL rd_empty_ptr: got %h empty=%b want 5a empty=0", o_rd_data, o_rx_empty);
    end
    pulse_rd();
    checks++; if (o_rx_empty !== 1'b1) begin fails++; $display("FAIL rd_empty_after: got %b want 1", o_rx_empty); end
  endtask

  task automatic test_tx_single();
    logic [7:0] d; logic st, sp; bit ok;
    pulse_wr(8'h0A);
    capture_tx(d, st, sp, ok);
    checks++; if (!ok) begin fails++; $display("FAIL tx1_timeout: no start bit seen"); end
    checks++; if (st !== 1'b0) begin fails++; $display("FAIL tx1_start: got %b want 0", st); end
    checks++; if (d !== 8'h0A) begin fails++; $display("FAIL tx1_data: got %h want 0a", d); end
    checks++; if (sp !== 1'b1) begin fails++; $display("FAIL tx1_stop: got %b want 1", sp); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [5];
    logic [7:0] d; logic st, sp; bit ok;
    bit seen;
    words = '{8'h0A, 8'h14, 8'h1E, 8'h28, 8'h32};
    clks(40);
    i_wr_uart = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_wr_data = words[i];
      clks(1);
      if (i == 3) begin
        checks++; if (o_tx_full !== 1'b1) begin fails++; $display("FAIL b2b_full: got %b want 1", o_tx_full); end
      end
    end
    i_wr_uart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      capture_tx(d, st, sp, ok);
      checks++;
      if (!ok || st !== 1'b0 || d !== words[i] || sp !== 1'b1) begin
        fails++;
        $display("FAIL b2b_frame%0d: got %h start=%b stop=%b seen=%b want %h", i, d, st, sp, ok, words[i]);
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      clks(1);
      if (o_tx !== 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin fails++; $display("FAIL b2b_no_fifth: extra frame started, want line idle"); end
    checks++; if (o_tx_full !== 1'b0) begin fails++; $display("FAIL b2b_drain_full: got %b want 0", o_tx_full); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d; logic st, sp; bit ok;
    bit seen;
    pulse_wr(8'h55);
    i_rx = 1'b0;
    clks(BITCLK * 3);
    i_rx = 1'b1;
    clks(BITCLK);
    i_reset = 1'b1;
    clks(1);
    i_reset = 1'b0;
    clks(1);
    checks++; if (o_tx !== 1'b1) begin fails++; $display("FAIL rst_mid_tx: got %b want 1", o_tx); end
    checks++; if (o_rx_empty !== 1'b1) begin fails++; $display("FAIL rst_mid_rx_empty: got %b want 1", o_rx_empty); end
    checks++; if (o_tx_full !== 1'b0) begin fails++; $display("FAIL rst_mid_tx_full: got %b want 0", o_tx_full); end
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      clks(1);
      if (o_tx !== 1'b1 || o_rx_empty !== 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin fails++; $display("FAIL rst_mid_partial: aborted frame resumed or stored"); end
    send_rx(8'h3C);
    checks++;
    if (o_rx_empty !== 1'b0 || o_rd_data !== 8'h3C) begin
      fails++; $display("FAIL rst_mid_rx_next: got %h empty=%b want 3c empty=0", o_rd_data, o_rx_empty);
    end
    pulse_rd();
    pulse_wr(8'hC3);
    capture_tx(d, st, sp, ok);
    checks++;
    if (!ok || st !== 1'b0 || d !== 8'hC3 || sp !== 1'b1) begin
      fails++; $display("FAIL rst_mid_tx_next: got %h start=%b stop=%b seen=%b want c3", d, st, sp, ok);
    end
  endtask

  initial begin
    test_reset();
    test_rx_single();
    test_rx_overflow();
    test_rx_read_empty();
    test_tx_single();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
